// File: rtl/ula_16_bits_seq_if.sv
// Request/response bus of the sequential 16-bit ALU.
// Optional accumulator-operand select port exists only when ULA_SEQ_ACCUM_EN is defined.
interface ula_16_bits_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_s;
  logic        req_m;
  logic        req_c_in;
`ifdef ULA_SEQ_ACCUM_EN
  logic        req_use_acc;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_f;
  logic        rsp_c_out;
  logic        rsp_a_eq_b;

  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_c_in,
`ifdef ULA_SEQ_ACCUM_EN
    output req_use_acc,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_c_in,
`ifdef ULA_SEQ_ACCUM_EN
    input  req_use_acc,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b
  );
endinterface

// File: rtl/ula_16_bits_seq.sv
// Sequential 16-bit ALU: one 8-bit ALU reused for a low-byte then a high-byte
// pass, carry chained between passes, result returned over valid/ready.
// Optional feature macro: ULA_SEQ_ACCUM_EN (operand A may come from the last result).

// 8-bit ALU, 74181-style function table with active-high data and carry.
// Arithmetic functions are expressed as x + y + c_in so the carry out is
// simply bit 8 of that sum. a_eq_b is a direct operand compare.
module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);
  logic [7:0] x, y, lg;
  logic [8:0] sum;

  // Arithmetic operand pair selection.
  always_comb begin
    x = a;
    y = 8'h00;
    case (s)
      4'b0000: begin x = a;        y = 8'h00;    end
      4'b0001: begin x = a | b;    y = 8'h00;    end
      4'b0010: begin x = a | ~b;   y = 8'h00;    end
      4'b0011: begin x = 8'h00;    y = 8'hFF;    end
      4'b0100: begin x = a;        y = a & ~b;   end
      4'b0101: begin x = a | b;    y = a & ~b;   end
      4'b0110: begin x = a;        y = ~b;       end
      4'b0111: begin x = a & ~b;   y = 8'hFF;    end
      4'b1000: begin x = a;        y = a & b;    end
      4'b1001: begin x = a;        y = b;        end
      4'b1010: begin x = a | ~b;   y = a & b;    end
      4'b1011: begin x = a & b;    y = 8'hFF;    end
      4'b1100: begin x = a;        y = a;        end
      4'b1101: begin x = a | b;    y = a;        end
      4'b1110: begin x = a | ~b;   y = a;        end
      default: begin x = a;        y = 8'hFF;    end
    endcase
  end

  // Logic-mode function table.
  always_comb begin
    lg = 8'h00;
    case (s)
      4'b0000: lg = ~a;
      4'b0001: lg = ~(a | b);
      4'b0010: lg = ~a & b;
      4'b0011: lg = 8'h00;
      4'b0100: lg = ~(a & b);
      4'b0101: lg = ~b;
      4'b0110: lg = a ^ b;
      4'b0111: lg = a & ~b;
      4'b1000: lg = ~a | b;
      4'b1001: lg = ~(a ^ b);
      4'b1010: lg = b;
      4'b1011: lg = a & b;
      4'b1100: lg = 8'hFF;
      4'b1101: lg = a | ~b;
      4'b1110: lg = a | b;
      default: lg = a;
    endcase
  end

  assign sum    = {1'b0, x} + {1'b0, y} + {8'h00, c_in};
  assign f      = m ? lg : sum[7:0];
  assign c_out  = m ? 1'b0 : sum[8];
  assign a_eq_b = (a == b);
endmodule

module ula_16_bits_seq (
  input logic               clk,
  input logic               rst,
  ula_16_bits_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state, state_nx;
  logic [15:0] a_q, b_q;
  logic [3:0]  s_q;
  logic        m_q, cin_q;
  logic [7:0]  f_lo;
  logic        c_lo, eq_lo;
  logic [15:0] rsp_f_q;
  logic        rsp_c_q, rsp_eq_q;
  logic        accept;
  logic [15:0] a_src;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic        alu_cin, alu_c, alu_eq;

  assign accept = bus.req_valid && bus.req_ready;

  // The accumulator is the registered result itself: it already resets to 0
  // and reloads on every HI edge, so no separate register is needed.
`ifdef ULA_SEQ_ACCUM_EN
  assign a_src = bus.req_use_acc ? rsp_f_q : bus.req_a;
`else
  assign a_src = bus.req_a;
`endif

  // Byte-pass mux: low byte in LO, high byte in HI; carry chains only in arithmetic mode.
  always_comb begin
    alu_a   = a_q[7:0];
    alu_b   = b_q[7:0];
    alu_cin = cin_q;
    if (state == HI) begin
      alu_a   = a_q[15:8];
      alu_b   = b_q[15:8];
      alu_cin = m_q ? cin_q : c_lo;
    end
  end

  ula_8_bits u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .s      (s_q),
    .m      (m_q),
    .c_in   (alu_cin),
    .f      (alu_f),
    .c_out  (alu_c),
    .a_eq_b (alu_eq)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = LO;
      end
      LO:   state_nx = HI;
      HI:   state_nx = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, low-pass capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cin_q    <= 1'b0;
      f_lo     <= '0;
      c_lo     <= 1'b0;
      eq_lo    <= 1'b0;
      rsp_f_q  <= '0;
      rsp_c_q  <= 1'b0;
      rsp_eq_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a_src;
        b_q   <= bus.req_b;
        s_q   <= bus.req_s;
        m_q   <= bus.req_m;
        cin_q <= bus.req_c_in;
      end
      if (state == LO) begin
        f_lo  <= alu_f;
        c_lo  <= alu_c;
        eq_lo <= alu_eq;
      end
      if (state == HI) begin
        rsp_f_q  <= {alu_f, f_lo};
        rsp_c_q  <= m_q ? 1'b0 : alu_c;
        rsp_eq_q <= eq_lo & alu_eq;
      end
    end
  end

  assign bus.rsp_f      = rsp_f_q;
  assign bus.rsp_c_out  = rsp_c_q;
  assign bus.rsp_a_eq_b = rsp_eq_q;
endmodule

// File: tb/tb_ula_16_bits_seq.sv
// Directed-vector bench for ula_16_bits_seq.
module tb_ula_16_bits_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  logic [15:0] r_f;
  logic        r_c, r_eq;
  int          r_lat;

  ula_16_bits_seq_if bus ();

  ula_16_bits_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, wait for response.
  // Leaves the bench #1 after the edge where rsp_valid rose.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic m, input logic cin, input logic use_acc);
    int n;
    @(negedge clk);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_s     = s;
    bus.req_m     = m;
    bus.req_c_in  = cin;
`ifdef ULA_SEQ_ACCUM_EN
    bus.req_use_acc = use_acc;
`endif
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_s     = ~s;
    bus.req_m     = ~m;
    bus.req_c_in  = ~cin;
`ifdef ULA_SEQ_ACCUM_EN
    bus.req_use_acc = ~use_acc;
`endif
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    r_lat = n;
    r_f   = bus.rsp_f;
    r_c   = bus.rsp_c_out;
    r_eq  = bus.rsp_a_eq_b;
  endtask

  // Finish the handshake (rsp_ready already high) and check the return to IDLE.
  task automatic drain(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
    chk({tag, "_valid_after"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold_f;
    logic        hold_c, hold_eq;
    int          seen;
    bus.req_valid = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_s = '0;
    bus.req_m = 1'b0; bus.req_c_in = 1'b0;
`ifdef ULA_SEQ_ACCUM_EN
    bus.req_use_acc = 1'b0;
`endif
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_f",     {16'b0, bus.rsp_f},     32'h0);
    chk("rst_rsp_c",     {31'b0, bus.rsp_c_out}, 32'd0);
    chk("rst_rsp_eq",    {31'b0, bus.rsp_a_eq_b},32'd0);

    // add with carry across the byte boundary
    do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("add_lat", r_lat, 32'd2);
    chk("add_f", {16'b0, r_f}, 32'h0100);
    chk("add_c", {31'b0, r_c}, 32'd0);
    chk("add_eq", {31'b0, r_eq}, 32'd0);
    drain("add");

    // overflow wraps, carry out reported
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("ovf_f", {16'b0, r_f}, 32'h0000);
    chk("ovf_c", {31'b0, r_c}, 32'd1);
    drain("ovf");

    // carry-in into the low pass, chained into the high pass
    do_op(16'h0000, 16'h00FF, 4'b1001, 1'b0, 1'b1, 1'b0);
    chk("cin_f", {16'b0, r_f}, 32'h0100);
    chk("cin_c", {31'b0, r_c}, 32'd0);
    drain("cin");

    // subtract: A - B - 1 + c_in with c_in=1
    do_op(16'h1234, 16'h0234, 4'b0110, 1'b0, 1'b1, 1'b0);
    chk("sub_f", {16'b0, r_f}, 32'h1000);
    chk("sub_c", {31'b0, r_c}, 32'd1);
    drain("sub");

    // equality flag in logic mode (F = ~A)
    do_op(16'hAAAA, 16'hAAAA, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("eq1_f", {16'b0, r_f}, 32'h5555);
    chk("eq1_eq", {31'b0, r_eq}, 32'd1);
    chk("eq1_c", {31'b0, r_c}, 32'd0);
    drain("eq1");
    do_op(16'hAAAA, 16'hAAAB, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("eq0_eq", {31'b0, r_eq}, 32'd0);
    chk("eq0_c", {31'b0, r_c}, 32'd0);
    drain("eq0");

    // logic XOR, c_in ignored, no carry reported
    do_op(16'h0F0F, 16'h00FF, 4'b0110, 1'b1, 1'b1, 1'b0);
    chk("xor_f", {16'b0, r_f}, 32'h0FF0);
    chk("xor_c", {31'b0, r_c}, 32'd0);
    drain("xor");

    // backpressure: response held, new requests ignored
    bus.rsp_ready = 1'b0;
    do_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("bp_f", {16'b0, r_f}, 32'h3333);
    hold_f = r_f; hold_c = r_c; hold_eq = r_eq;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_a = 16'h0005 + 16'(i);
      bus.req_b = 16'h0005;
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_hold", {14'b0, bus.rsp_f, bus.rsp_c_out, bus.rsp_a_eq_b},
          {14'b0, hold_f, hold_c, hold_eq});
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain("bp");
    chk("bp_idle_ready2", {31'b0, bus.req_ready}, 32'd1);
    do_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("post_bp_f", {16'b0, r_f}, 32'h0002);
    drain("post_bp");

    // reset asserted while in HI
    @(negedge clk);
    bus.req_a = 16'h4000; bus.req_b = 16'h0100; bus.req_s = 4'b1001;
    bus.req_m = 1'b0; bus.req_c_in = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;           // accepted, now LO
    bus.req_valid = 1'b0;
    @(posedge clk); #1;           // now HI
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_f", {16'b0, bus.rsp_f}, 32'h0);
    chk("mid_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    chk("mid_rst_no_rsp", seen, 32'd0);

`ifdef ULA_SEQ_ACCUM_EN
    do_op(16'h0010, 16'h0005, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("acc1_f", {16'b0, r_f}, 32'h0015);
    drain("acc1");
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
    chk("acc2_f", {16'b0, r_f}, 32'h0016);
    drain("acc2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
